hex_display_ctrl: RTL and testbench

- Register-mapped controller that sequences the six on-board 7-segment digits (HEX0..HEX5) from a CPU-side PIO write/read port.
- Replaces direct PIO-to-HEX wiring so software writes hex values once and the block handles decode, per-digit blanking, blinking and rotating scroll.
- Sits between the Platform Designer PIO exports and the top-level HEX pins.

---
 rtl/hex_display_pkg.sv | 49 ++++
 rtl/hex_seg_decode.sv | 17 +
 rtl/hex_display_ctrl.sv | 177 +++++++++++++++++
 tb/tb_hex_display_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_pkg
// Purpose  : Shared constants for the six-digit HEX display controller:
//            register map, CTRL bit positions, segment table, helpers.
// Revision : 1.0  initial release
// ============================================================================
package hex_display_pkg;

  localparam int NUM_DIGITS = 6;

  // Register map
  localparam logic [2:0] ADDR_DIG [NUM_DIGITS] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  localparam logic [2:0] ADDR_CTRL   = 3'd6;
  localparam logic [2:0] ADDR_STATUS = 3'd7;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_BLINK  = 1;
  localparam int CTRL_SCROLL = 2;
  localparam int CTRL_DIR    = 3;

  // Blank flag position inside a DIGn register
  localparam int DIG_BLANK = 7;

  // All segments off (active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7f;

  // Active-low gfedcba patterns for 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e
  };

  typedef enum logic [0:0] {
    SCROLL_IDLE = 1'b0,
    SCROLL_RUN  = 1'b1
  } scroll_state_t;

  // Digit shown at display position pos for a given rotation: (pos+offset) mod 6
  function automatic logic [2:0] rot_index(input logic [2:0] pos, input logic [2:0] offset);
    logic [3:0] sum;
    sum = {1'b0, pos} + {1'b0, offset};
    if (sum >= 4'd6) sum = sum - 4'd6;
    return sum[2:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_seg_decode.sv
`default_nettype none
// ============================================================================
// Module   : hex_seg_decode
// Purpose  : Combinational 4-bit hex value to active-low 7-segment pattern.
// Revision : 1.0  initial release
// ============================================================================
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[value];

endmodule
`default_nettype wire

// File: rtl/hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_ctrl
// Purpose  : Register-mapped controller for six 7-segment digits with
//            per-digit blanking, global blink and rotating scroll.
// Revision : 1.0  initial release
// ============================================================================
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int BLINK_HZ  = 2,
  parameter int SCROLL_HZ = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [2:0] addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5
);

  localparam int BLINK_HALF    = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCROLL_PERIOD = CLK_HZ / SCROLL_HZ;
  localparam int BLINK_W       = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int SCROLL_W      = (SCROLL_PERIOD > 1) ? $clog2(SCROLL_PERIOD) : 1;
  localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_HALF - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_PERIOD - 1);

  logic [7:0]          dig [NUM_DIGITS];
  logic [3:0]          ctrl;
  logic [2:0]          offset;
  logic                phase;
  logic [BLINK_W-1:0]  blink_cnt;
  logic [SCROLL_W-1:0] scroll_cnt;
  scroll_state_t       state;
  logic [6:0]          seg [NUM_DIGITS];
  logic [6:0]          hex_next [NUM_DIGITS];
  logic [6:0]          hex_q [NUM_DIGITS];
  logic [7:0]          rd_next;
  logic                ctrl_wr;
  logic                blink_tick;
  logic                scroll_tick;
  logic [2:0]          offset_step;
  logic                unused_wr_bits;

  // Data bits 6:4 of a digit write are dropped on purpose
  assign unused_wr_bits = ^wr_data[6:4];

  assign ctrl_wr     = wr_en && (addr == ADDR_CTRL);
  assign blink_tick  = (blink_cnt == BLINK_LAST);
  assign scroll_tick = (scroll_cnt == SCROLL_LAST);

  // Left rotation counts up, right rotation counts down, both modulo 6
  assign offset_step = ctrl[CTRL_DIR] ? ((offset == 3'd0) ? 3'd5 : offset - 3'd1)
                                      : ((offset == 3'd5) ? 3'd0 : offset + 3'd1);

  // Register file: digit values with blank flag, and the control bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= 8'h80;
      ctrl <= 4'h0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (addr == ADDR_DIG[i]) dig[i] <= {wr_data[DIG_BLANK], 3'b000, wr_data[3:0]};
      end
      if (ctrl_wr) ctrl <= wr_data[3:0];
    end
  end

  // Blink prescaler; a CTRL write in the tick cycle suppresses the toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (ctrl_wr && !wr_data[CTRL_BLINK]) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (ctrl[CTRL_BLINK]) begin
      if (blink_tick) begin
        blink_cnt <= '0;
        if (!ctrl_wr) phase <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Scroll FSM with its step prescaler and rotation offset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SCROLL_IDLE;
      offset     <= 3'd0;
      scroll_cnt <= '0;
    end else begin
      case (state)
        SCROLL_IDLE: begin
          if (ctrl_wr && wr_data[CTRL_SCROLL]) state <= SCROLL_RUN;
        end
        SCROLL_RUN: begin
          if (ctrl_wr && !wr_data[CTRL_SCROLL]) begin
            state      <= SCROLL_IDLE;
            offset     <= 3'd0;
            scroll_cnt <= '0;
          end else if (scroll_tick) begin
            scroll_cnt <= '0;
            if (!ctrl_wr) offset <= offset_step;
          end else begin
            scroll_cnt <= scroll_cnt + SCROLL_W'(1);
          end
        end
        default: state <= SCROLL_IDLE;
      endcase
    end
  end

  // Read mux
  always_comb begin
    rd_next = 8'h00;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (addr == ADDR_DIG[i]) rd_next = dig[i];
    end
    if (addr == ADDR_CTRL)   rd_next = {4'h0, ctrl};
    if (addr == ADDR_STATUS) rd_next = {4'h0, phase, offset};
  end

  // Read data register, held between read strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= 8'h00;
    else if (rd_en) rd_data <= rd_next;
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
      hex_seg_decode u_dec (
        .value (dig[gi][3:0]),
        .seg   (seg[gi])
      );
    end
  endgenerate

  // Rotation select and blanking for every display position
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_next[i] = seg[rot_index(3'(i), offset)];
      if (!ctrl[CTRL_EN] || (ctrl[CTRL_BLINK] && !phase) ||
          dig[rot_index(3'(i), offset)][DIG_BLANK]) begin
        hex_next[i] = SEG_BLANK;
      end
    end
  end

  // Output registers driving the HEX pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= SEG_BLANK;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= hex_next[i];
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule
`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_ctrl
// Purpose  : Self-checking bench for hex_display_ctrl (CLK_HZ=16, BLINK_HZ=2,
//            SCROLL_HZ=4: blink half-period 4 cycles, scroll step 4 cycles).
// Revision : 1.0  initial release
// ============================================================================
module tb_hex_display_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic       rd_en;
  logic [2:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic [6:0] exp_hex;
  } vec_t;

  vec_t vecs [19];

  // Expected HEX pattern for the digit values 0..5
  logic [6:0] seg_exp [6];

  hex_display_ctrl #(
    .CLK_HZ    (16),
    .BLINK_HZ  (2),
    .SCROLL_HZ (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .hex3    (hex3),
    .hex4    (hex4),
    .hex5    (hex5)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_hex(input string name, input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3,
                           input logic [6:0] e4, input logic [6:0] e5);
    check({name, "_hex0"}, 32'(hex0), 32'(e0));
    check({name, "_hex1"}, 32'(hex1), 32'(e1));
    check({name, "_hex2"}, 32'(hex2), 32'(e2));
    check({name, "_hex3"}, 32'(hex3), 32'(e3));
    check({name, "_hex4"}, 32'(hex4), 32'(e4));
    check({name, "_hex5"}, 32'(hex5), 32'(e5));
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
    rd_en = 1'b1; addr = a;
    tick(1);
    rd_en = 1'b0;
    d = rd_data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r;
    logic [7:0] exp_r;
    logic [6:0] exp_h;

    vecs[0]  = '{8'h00, 8'h00, 7'h40};
    vecs[1]  = '{8'h01, 8'h01, 7'h79};
    vecs[2]  = '{8'h02, 8'h02, 7'h24};
    vecs[3]  = '{8'h03, 8'h03, 7'h30};
    vecs[4]  = '{8'h04, 8'h04, 7'h19};
    vecs[5]  = '{8'h05, 8'h05, 7'h12};
    vecs[6]  = '{8'h06, 8'h06, 7'h02};
    vecs[7]  = '{8'h07, 8'h07, 7'h78};
    vecs[8]  = '{8'h08, 8'h08, 7'h00};
    vecs[9]  = '{8'h09, 8'h09, 7'h10};
    vecs[10] = '{8'h0A, 8'h0A, 7'h08};
    vecs[11] = '{8'h0B, 8'h0B, 7'h03};
    vecs[12] = '{8'h0C, 8'h0C, 7'h46};
    vecs[13] = '{8'h0D, 8'h0D, 7'h21};
    vecs[14] = '{8'h0E, 8'h0E, 7'h06};
    vecs[15] = '{8'h0F, 8'h0F, 7'h0e};
    vecs[16] = '{8'h7A, 8'h0A, 7'h08};
    vecs[17] = '{8'h85, 8'h85, 7'h7f};
    vecs[18] = '{8'hF3, 8'h83, 7'h7f};

    seg_exp = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};

    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 3'd0; wr_data = 8'h00;
    tick(2);

    // Reset state
    check_hex("reset", 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f);
    check("reset_rd_data", 32'(rd_data), 32'h00);
    rst_n = 1'b1;
    tick(1);
    for (int a = 0; a < 8; a++) begin
      read_reg(3'(a), r);
      exp_r = (a < 6) ? 8'h80 : ((a == 6) ? 8'h00 : 8'h08);
      check($sformatf("reset_reg%0d", a), 32'(r), 32'(exp_r));
    end

    // STATUS is read-only
    write_reg(3'd7, 8'hFF);
    read_reg(3'd7, r);
    check("status_write_ignored", 32'(r), 32'h08);

    // Simultaneous read and write of the same register returns the old value
    rd_en = 1'b1; wr_en = 1'b1; addr = 3'd0; wr_data = 8'h05;
    tick(1);
    rd_en = 1'b0; wr_en = 1'b0;
    check("rd_wr_same_cycle", 32'(rd_data), 32'h80);
    tick(3);
    check("rd_data_hold", 32'(rd_data), 32'h80);
    read_reg(3'd0, r);
    check("rd_after_wr", 32'(r), 32'h05);

    // Load 0..5 and enable; pins update on the second edge after the write
    for (int i = 0; i < 6; i++) write_reg(3'(i), 8'(i));
    write_reg(3'd6, 8'h01);
    check("en_not_yet_visible", 32'(hex0), 32'h7f);
    tick(1);
    check_hex("en_decode", 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12);
    read_reg(3'd6, r);
    check("ctrl_read", 32'(r), 32'h01);

    // Decode table through DIG0
    for (int v = 0; v < 19; v++) begin
      write_reg(3'd0, vecs[v].wdata);
      tick(1);
      check($sformatf("vec%0d_hex0", v), 32'(hex0), 32'(vecs[v].exp_hex));
      read_reg(3'd0, r);
      check($sformatf("vec%0d_rd", v), 32'(r), 32'(vecs[v].exp_rd));
    end
    write_reg(3'd0, 8'h00);
    tick(1);

    // Blink: visible for edges 1..4, blank 5..8, visible 9..12
    write_reg(3'd6, 8'h03);
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      exp_h = ((((k - 1) / 4) % 2) == 0) ? 7'h40 : 7'h7f;
      check($sformatf("blink_k%0d_hex0", k), 32'(hex0), 32'(exp_h));
    end
    // Phase is 0 here; clearing BLINK forces it visible and keeps it there
    write_reg(3'd6, 8'h01);
    for (int j = 0; j < 8; j++) begin
      tick(1);
      check($sformatf("blink_off_j%0d_hex0", j), 32'(hex0), 32'h40);
    end
    read_reg(3'd7, r);
    check("blink_off_status", 32'(r), 32'h08);

    // Scroll left: offset 1,2,3,4,5,0 every 4 cycles
    write_reg(3'd6, 8'h05);
    tick(4);
    for (int k = 1; k <= 6; k++) begin
      read_reg(3'd7, r);
      check($sformatf("scroll_k%0d_status", k), 32'(r), 32'(8'h08 | 8'(k % 6)));
      check($sformatf("scroll_k%0d_hex0", k), 32'(hex0), 32'(seg_exp[k % 6]));
      if (k != 6) tick(3);
    end

    // Direction change at offset 0 keeps the counter; next tick gives 5
    write_reg(3'd6, 8'h0D);
    tick(2);
    read_reg(3'd7, r);
    check("scroll_right_status", 32'(r), 32'h0D);
    check("scroll_right_hex0", 32'(hex0), 32'h12);

    // CTRL write on a tick cycle (still scrolling): tick is discarded
    tick(2);
    write_reg(3'd6, 8'h0D);
    read_reg(3'd7, r);
    check("ctrl_wins_tick_status", 32'(r), 32'h0D);

    // CTRL write clearing SCROLL on a tick cycle: offset goes to 0
    tick(2);
    write_reg(3'd6, 8'h01);
    read_reg(3'd7, r);
    check("scroll_stop_status", 32'(r), 32'h08);
    tick(8);
    read_reg(3'd7, r);
    check("scroll_idle_status", 32'(r), 32'h08);

    // Reset mid-scroll with blink active
    write_reg(3'd6, 8'h07);
    tick(10);
    read_reg(3'd7, r);
    check("pre_reset_status", 32'(r), 32'h0A);
    check("pre_reset_hex0_a", 32'(hex0), 32'h24);
    tick(1);
    check("pre_reset_hex0_b", 32'(hex0), 32'h24);
    #2;
    rst_n = 1'b0;
    #1;
    check_hex("async_reset", 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f);
    check("async_reset_rd_data", 32'(rd_data), 32'h00);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    read_reg(3'd7, r);
    check("post_reset_status", 32'(r), 32'h08);
    read_reg(3'd6, r);
    check("post_reset_ctrl", 32'(r), 32'h00);
    read_reg(3'd3, r);
    check("post_reset_dig3", 32'(r), 32'h80);
    check_hex("post_reset", 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
